// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus responder.
package dbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_WR_WAIT,
    ST_TX_HOLD,
    ST_WR_DONE
  } dbus_state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_OOR
  } dbus_region_e;

  // Word offsets inside the peripheral window (d_addr[3:2]).
  localparam logic [1:0] MMIO_TIMER   = 2'd0;
  localparam logic [1:0] MMIO_CONSOLE = 2'd1;
  localparam logic [1:0] MMIO_STATUS  = 2'd2;

endpackage

// File: rtl/dbus_resp_if.sv
// Load/store handshake between the core (master) and the data-bus responder (slave).
interface dbus_resp_if;

  logic [31:0] d_addr;
  logic        d_rd_req;
  logic        d_rd_ready;
  logic [31:0] d_rd_data;
  logic        d_wr_req;
  logic        d_wr_ready;
  logic [3:0]  d_wr_be;
  logic [31:0] d_wr_data;

  modport master (
    output d_addr, d_rd_req, d_wr_req, d_wr_be, d_wr_data,
    input  d_rd_ready, d_rd_data, d_wr_ready
  );

  modport slave (
    input  d_addr, d_rd_req, d_wr_req, d_wr_be, d_wr_data,
    output d_rd_ready, d_rd_data, d_wr_ready
  );

endinterface

// File: rtl/dbus_ram.sv
// Single-port data RAM: synchronous read, per-byte write enables, no reset.
module dbus_ram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dbus_resp.sv
// Data-bus responder: RAM + peripheral window (timer, console, status) with wait states.
module dbus_resp
  import dbus_pkg::*;
#(
  parameter int         DEPTH    = 1024,
  parameter int         RD_WAIT  = 0,
  parameter int         WR_WAIT  = 0,
  parameter logic [3:0] MMIO_NIB = 4'hF
) (
  input  logic       clk,
  input  logic       rstb,
  dbus_resp_if.slave bus,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       bus_err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  dbus_state_e  state;
  logic [3:0]   cnt;
  logic [AW-1:0] lat_word;
  logic [1:0]   lat_off;
  logic [3:0]   lat_be;
  logic [31:0]  lat_data;
  dbus_region_e lat_rgn;
  dbus_region_e req_rgn;
  logic [31:0]  timer;
  logic [31:0]  ram_q;
  logic [AW-1:0] ram_addr;
  logic [3:0]   ram_we;
  logic [31:0]  rd_mux;
  logic         rd_ready;
  logic         wr_ready;
  logic [31:0]  rd_data;
  logic         wait_done;
  logic         err_set;
  logic         err_clr;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^bus.d_addr[1:0];

  assign bus.d_rd_ready = rd_ready;
  assign bus.d_wr_ready = wr_ready;
  assign bus.d_rd_data  = rd_data;

  // Region decode of the live request address; only consumed while IDLE.
  always_comb begin
    if (bus.d_addr[31:28] == MMIO_NIB)     req_rgn = RGN_MMIO;
    else if (bus.d_addr[27:2] < 26'(DEPTH)) req_rgn = RGN_RAM;
    else                                    req_rgn = RGN_OOR;
  end

  // RAM is addressed from the bus in IDLE so the word is already out when a zero-wait read finishes.
  assign ram_addr  = (state == ST_IDLE) ? bus.d_addr[AW+1:2] : lat_word;
  assign wait_done = (cnt == 4'd0);
  assign ram_we    = (state == ST_WR_WAIT && wait_done && lat_rgn == RGN_RAM) ? lat_be : 4'b0000;

  assign err_set = ((state == ST_RD_WAIT) || (state == ST_WR_WAIT)) && wait_done && (lat_rgn == RGN_OOR);
  assign err_clr = (state == ST_WR_WAIT) && wait_done && (lat_rgn == RGN_MMIO) &&
                   (lat_off == MMIO_STATUS) && lat_be[0] && lat_data[0];

  // Read data source selected by the latched region/offset.
  always_comb begin
    rd_mux = '0;
    if (lat_rgn == RGN_RAM) begin
      rd_mux = ram_q;
    end else if (lat_rgn == RGN_MMIO) begin
      case (lat_off)
        MMIO_TIMER:  rd_mux = timer;
        MMIO_STATUS: rd_mux = {31'b0, bus_err};
        default:     rd_mux = '0;
      endcase
    end
  end

  dbus_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (lat_data),
    .rdata (ram_q)
  );

  // Free-running clock count since reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) timer <= '0;
    else       timer <= timer + 32'd1;
  end

  // Transaction FSM with registered strobes, console output and sticky error.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_word <= '0;
      lat_off  <= '0;
      lat_be   <= '0;
      lat_data <= '0;
      lat_rgn  <= RGN_RAM;
      rd_ready <= 1'b0;
      wr_ready <= 1'b0;
      rd_data  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      bus_err  <= 1'b0;
    end else begin
      rd_ready <= 1'b0;
      wr_ready <= 1'b0;
      // A set on the same edge as a clear wins.
      bus_err  <= err_set | (bus_err & ~err_clr);
      case (state)
        ST_IDLE: begin
          if (bus.d_rd_req || bus.d_wr_req) begin
            lat_word <= bus.d_addr[AW+1:2];
            lat_off  <= bus.d_addr[3:2];
            lat_rgn  <= req_rgn;
          end
          if (bus.d_rd_req) begin
            state <= ST_RD_WAIT;
            cnt   <= RD_CNT;
          end else if (bus.d_wr_req) begin
            state    <= ST_WR_WAIT;
            cnt      <= WR_CNT;
            lat_be   <= bus.d_wr_be;
            lat_data <= bus.d_wr_data;
          end
        end
        ST_RD_WAIT: begin
          if (!wait_done) begin
            cnt <= cnt - 4'd1;
          end else begin
            rd_data  <= rd_mux;
            rd_ready <= 1'b1;
            state    <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: state <= ST_IDLE;
        ST_WR_WAIT: begin
          if (!wait_done) begin
            cnt <= cnt - 4'd1;
          end else if (lat_rgn == RGN_MMIO && lat_off == MMIO_CONSOLE && lat_be[0]) begin
            tx_valid <= 1'b1;
            tx_data  <= lat_data[7:0];
            state    <= ST_TX_HOLD;
          end else begin
            wr_ready <= 1'b1;
            state    <= ST_WR_DONE;
          end
        end
        ST_TX_HOLD: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            wr_ready <= 1'b1;
            state    <= ST_WR_DONE;
          end
        end
        ST_WR_DONE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_resp.sv
// Directed bench for dbus_resp: a zero-wait instance and a RD_WAIT=2/WR_WAIT=3 instance.
module tb_dbus_resp;

  logic        clk      = 1'b0;
  logic        rstb     = 1'b0;
  logic        zsel     = 1'b0;
  logic [31:0] addr     = '0;
  logic [31:0] wdata    = '0;
  logic [3:0]  be       = '0;
  logic        rd_req   = 1'b0;
  logic        wr_req   = 1'b0;
  logic        tx_ready = 1'b0;

  logic        tx_valid, z_tx_valid;
  logic [7:0]  tx_data, z_tx_data;
  logic        bus_err, z_bus_err;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  int unsigned tcap  = 0;

  always #5 clk = ~clk;

  dbus_resp_if bus ();
  dbus_resp_if bz ();

  assign bus.d_addr    = addr;
  assign bus.d_wr_be   = be;
  assign bus.d_wr_data = wdata;
  assign bus.d_rd_req  = rd_req & ~zsel;
  assign bus.d_wr_req  = wr_req & ~zsel;
  assign bz.d_addr     = addr;
  assign bz.d_wr_be    = be;
  assign bz.d_wr_data  = wdata;
  assign bz.d_rd_req   = rd_req & zsel;
  assign bz.d_wr_req   = wr_req & zsel;

  dbus_resp #(.DEPTH(1024), .RD_WAIT(2), .WR_WAIT(3), .MMIO_NIB(4'hF)) dut (
    .clk(clk), .rstb(rstb), .bus(bus),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .bus_err(bus_err)
  );

  dbus_resp #(.DEPTH(1024), .RD_WAIT(0), .WR_WAIT(0), .MMIO_NIB(4'hF)) dutz (
    .clk(clk), .rstb(rstb), .bus(bz),
    .tx_valid(z_tx_valid), .tx_data(z_tx_data), .tx_ready(1'b1), .bus_err(z_bus_err)
  );

  wire        rd_ready = zsel ? bz.d_rd_ready : bus.d_rd_ready;
  wire        wr_ready = zsel ? bz.d_wr_ready : bus.d_wr_ready;
  wire [31:0] rd_data  = zsel ? bz.d_rd_data  : bus.d_rd_data;

  // Reference count of clock edges since reset release.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy(input bit wr, output int n);
    logic rdy;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 64) begin
      @(posedge clk);
      #1;
      n++;
      rdy = wr ? wr_ready : rd_ready;
    end
    chk(wr ? "wr_ready_seen" : "rd_ready_seen", {31'b0, rdy}, 32'd1);
    tcap = cyc;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int n);
    @(negedge clk);
    addr   = a;
    rd_req = 1'b1;
    wait_rdy(1'b0, n);
    d = rd_data;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, output int n);
    @(negedge clk);
    addr   = a;
    be     = b;
    wdata  = d;
    wr_req = 1'b1;
    wait_rdy(1'b1, n);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    int          nv;
    int          wr_at;
    int          last_tv;
    logic [7:0]  txd;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_ready", bus.d_rd_ready, 0);
    chk("rst_wr_ready", bus.d_wr_ready, 0);
    chk("rst_rd_data",  bus.d_rd_data,  0);
    chk("rst_tx",       {23'b0, tx_valid, tx_data}, 0);
    chk("rst_bus_err",  bus_err, 0);
    @(negedge clk);
    rstb = 1'b1;

    // Zero-wait instance: latency 2 and address LSBs ignored
    zsel = 1'b1;
    do_write(32'h14, 4'hF, 32'hDEAD_BEEF, n);
    chk("z_wr_lat", n, 2);
    do_read(32'h14, d, n);
    chk("z_rd_lat", n, 2);
    chk("z_rd_14", d, 32'hDEAD_BEEF);
    for (int k = 1; k < 4; k++) begin
      do_read(32'h14 + k, d, n);
      chk("z_rd_lsb", d, 32'hDEAD_BEEF);
    end
    chk("z_side", {22'b0, z_tx_valid, z_bus_err, z_tx_data}, 0);
    zsel = 1'b0;

    // Byte-enable merge on the waited instance
    do_write(32'h40, 4'hF, 32'h1122_3344, n);
    chk("wr_lat", n, 5);
    do_write(32'h40, 4'b0100, 32'h00AB_0000, n);
    do_read(32'h40, d, n);
    chk("rd_lat", n, 4);
    chk("be_0100", d, 32'h11AB_3344);
    do_write(32'h40, 4'b1100, 32'h5566_7788, n);
    do_read(32'h40, d, n);
    chk("be_1100", d, 32'h5566_3344);
    do_write(32'h40, 4'hF, 32'hA5A5_5A5A, n);
    do_read(32'h40, d, n);
    chk("be_1111", d, 32'hA5A5_5A5A);

    // Back-to-back loads with request held high
    do_write(32'h100, 4'hF, 32'h1111_0001, n);
    do_write(32'h104, 4'hF, 32'h2222_0002, n);
    @(negedge clk);
    addr   = 32'h100;
    rd_req = 1'b1;
    wait_rdy(1'b0, n);
    chk("b2b_first", rd_data, 32'h1111_0001);
    @(negedge clk);
    addr = 32'h104;
    wait_rdy(1'b0, n);
    chk("b2b_gap", n, 5);
    chk("b2b_second", rd_data, 32'h2222_0002);
    @(negedge clk);
    rd_req = 1'b0;

    // Simultaneous read and write: read first, write after one IDLE
    do_write(32'h200, 4'hF, 32'hAAAA_0000, n);
    @(negedge clk);
    addr   = 32'h200;
    be     = 4'hF;
    wdata  = 32'hBBBB_1111;
    rd_req = 1'b1;
    wr_req = 1'b1;
    wait_rdy(1'b0, n);
    chk("both_rd_data", rd_data, 32'hAAAA_0000);
    chk("both_wr_idle", bus.d_wr_ready, 0);
    @(negedge clk);
    rd_req = 1'b0;
    wait_rdy(1'b1, n);
    chk("both_wr_gap", n, 6);
    @(negedge clk);
    wr_req = 1'b0;
    do_read(32'h200, d, n);
    chk("both_wr_data", d, 32'hBBBB_1111);

    // Console write without lane 0: plain completion, no byte
    do_write(32'hF000_0004, 4'b0010, 32'h0000_4100, n);
    chk("con_nobe_lat", n, 5);
    chk("con_nobe_tx", tx_valid, 0);

    // Console write with sink stalled for 4 cycles
    @(negedge clk);
    addr    = 32'hF000_0004;
    be      = 4'b0001;
    wdata   = 32'h0000_0041;
    wr_req  = 1'b1;
    nv      = 0;
    wr_at   = -1;
    last_tv = -1;
    txd     = 8'h00;
    for (int k = 0; k < 30 && wr_at < 0; k++) begin
      @(posedge clk);
      #1;
      if (tx_valid) begin
        nv++;
        last_tv = k;
        txd     = tx_data;
      end
      if (bus.d_wr_ready) wr_at = k;
      @(negedge clk);
      tx_ready = (nv == 5) && tx_valid;
      if (wr_at >= 0) wr_req = 1'b0;
    end
    wr_req   = 1'b0;
    tx_ready = 1'b0;
    chk("con_valid_cycles", nv, 5);
    chk("con_data", {24'b0, txd}, 32'h41);
    chk("con_ready_after", wr_at, last_tv + 1);

    // Last in-range word, then out-of-range behaviour and STATUS
    do_write(32'h0, 4'hF, 32'h0BAD_0000, n);
    do_write(32'hFFC, 4'hF, 32'h7777_0FFC, n);
    do_read(32'hFFC, d, n);
    chk("last_word", d, 32'h7777_0FFC);
    chk("last_word_err", bus_err, 0);
    do_read(32'h1000, d, n);
    chk("oor_rd_data", d, 0);
    chk("oor_err_set", bus_err, 1);
    do_read(32'hF000_0008, d, n);
    chk("status_rd", d, 1);
    do_write(32'h1000, 4'hF, 32'h1234_5678, n);
    do_read(32'h0, d, n);
    chk("oor_wr_drop", d, 32'h0BAD_0000);
    do_write(32'hF000_0008, 4'b0000, 32'h1, n);
    chk("status_nobe", bus_err, 1);
    do_write(32'hF000_0008, 4'b0001, 32'h1, n);
    chk("status_clr", bus_err, 0);
    do_read(32'hF000_0004, d, n);
    chk("console_rd", d, 0);
    do_read(32'hF000_000C, d, n);
    chk("resv_rd", d, 0);

    // TIMER reads: value at the completing edge, writes ignored
    do_read(32'hF000_0000, d, n);
    chk("timer_rd", d, tcap - 1);
    do_write(32'hF000_0000, 4'hF, 32'h0, n);
    do_read(32'hF000_0000, d, n);
    chk("timer_rd_after_wr", d, tcap - 1);

    // TIMER wrap
    @(negedge clk);
    force dut.timer = 32'hFFFF_FFFE;
    release dut.timer;
    @(posedge clk);
    #1;
    chk("timer_max", dut.timer, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("timer_wrap", dut.timer, 0);

    // Reset during WR_WAIT: no commit, outputs cleared
    do_write(32'h300, 4'hF, 32'h600D_F00D, n);
    do_read(32'h1000, d, n);
    do_read(32'h300, d, n);
    chk("pre_rst_word", d, 32'h600D_F00D);
    @(negedge clk);
    addr   = 32'h300;
    be     = 4'hF;
    wdata  = 32'hBAD0_BAD0;
    wr_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    wr_req = 1'b0;
    chk("abort_wr_ready", bus.d_wr_ready, 0);
    chk("abort_rd_ready", bus.d_rd_ready, 0);
    chk("abort_rd_data",  bus.d_rd_data,  0);
    chk("abort_tx",       {23'b0, tx_valid, tx_data}, 0);
    chk("abort_bus_err",  bus_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    do_read(32'h300, d, n);
    chk("abort_no_commit", d, 32'h600D_F00D);

    // Reset during TX_HOLD drops tx_valid without a clock
    @(negedge clk);
    addr   = 32'hF000_0004;
    be     = 4'b0001;
    wdata  = 32'h0000_005A;
    wr_req = 1'b1;
    for (int k = 0; k < 20 && !tx_valid; k++) begin
      @(posedge clk);
      #1;
    end
    chk("tx_hold_seen", tx_valid, 1);
    #2;
    rstb = 1'b0;
    #1;
    wr_req = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_tx_wr_ready", bus.d_wr_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
